// File: rtl/seq_divider_nbit.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, start/done handshake.
// The trial subtract is an add of the inverted divisor, and the carry-out is the sign test.
module seq_divider_nbit #(
  parameter int unsigned n = 4
) (
  input  logic         in_clk,
  input  logic         in_rst,
  input  logic         in_start,
  input  logic [n-1:0] in_dividend,
  input  logic [n-1:0] in_divisor,
  output logic [n-1:0] out_quotient,
  output logic [n-1:0] out_remainder,
  output logic         out_busy,
  output logic         out_done,
  output logic         out_div_zero
);

  localparam int unsigned CW = $clog2(n + 1);
  localparam int unsigned SW = n + 2;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [n-1:0]  work_q;
  logic [n-1:0]  dvsr;
  logic [n:0]    rem;
  logic [CW-1:0] cnt;

  logic [n:0]    shifted;
  logic [SW-1:0] sum;
  logic          carry;
  logic [n-1:0]  q_next;
  logic [n:0]    r_next;

  // One restoring step: shift in the next dividend bit, trial-subtract, keep or restore.
  always_comb begin
    shifted = {rem[n-1:0], work_q[n-1]};
    sum     = {1'b0, shifted} + {1'b0, ~{1'b0, dvsr}} + SW'(1);
    carry   = sum[n+1];
    q_next  = {work_q[n-2:0], carry};
    r_next  = carry ? sum[n:0] : shifted;
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state         <= IDLE;
      work_q        <= '0;
      dvsr          <= '0;
      rem           <= '0;
      cnt           <= '0;
      out_quotient  <= '0;
      out_remainder <= '0;
      out_busy      <= 1'b0;
      out_done      <= 1'b0;
      out_div_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          out_done <= 1'b0;
          if (in_start) begin
            dvsr   <= in_divisor;
            work_q <= in_dividend;
            rem    <= '0;
            cnt    <= '0;
            // A zero divisor skips iteration and reports the saturated result at once.
            if (in_divisor == '0) begin
              state         <= DONE;
              out_quotient  <= '1;
              out_remainder <= in_dividend;
              out_div_zero  <= 1'b1;
              out_done      <= 1'b1;
            end else begin
              state    <= RUN;
              out_busy <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          work_q <= q_next;
          rem    <= r_next;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(n - 1)) begin
            state         <= DONE;
            out_busy      <= 1'b0;
            out_done      <= 1'b1;
            out_quotient  <= q_next;
            out_remainder <= r_next[n-1:0];
            out_div_zero  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_nbit.sv
// Bench for seq_divider_nbit: n=4 and n=8 instances checked against plain integer division.
module tb_seq_divider_nbit;

  logic       clk = 1'b0;
  logic       rst4, rst8, st4, st8;
  logic [3:0] a4, b4, q4, r4;
  logic [7:0] a8, b8, q8, r8;
  logic       busy4, done4, dz4, busy8, done8, dz8;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  seq_divider_nbit #(.n(4)) dut4 (
    .in_clk(clk), .in_rst(rst4), .in_start(st4), .in_dividend(a4), .in_divisor(b4),
    .out_quotient(q4), .out_remainder(r4), .out_busy(busy4), .out_done(done4),
    .out_div_zero(dz4)
  );

  seq_divider_nbit #(.n(8)) dut8 (
    .in_clk(clk), .in_rst(rst8), .in_start(st8), .in_dividend(a8), .in_divisor(b8),
    .out_quotient(q8), .out_remainder(r8), .out_busy(busy8), .out_done(done8),
    .out_div_zero(dz8)
  );

  function automatic logic [31:0] obs_q(input bit w);
    return w ? {24'b0, q8} : {28'b0, q4};
  endfunction
  function automatic logic [31:0] obs_r(input bit w);
    return w ? {24'b0, r8} : {28'b0, r4};
  endfunction
  function automatic logic [31:0] obs_busy(input bit w);
    return w ? {31'b0, busy8} : {31'b0, busy4};
  endfunction
  function automatic logic [31:0] obs_done(input bit w);
    return w ? {31'b0, done8} : {31'b0, done4};
  endfunction
  function automatic logic [31:0] obs_dz(input bit w);
    return w ? {31'b0, dz8} : {31'b0, dz4};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input bit w, input string tag);
    chk({tag, " q"}, obs_q(w), 0);
    chk({tag, " r"}, obs_r(w), 0);
    chk({tag, " busy"}, obs_busy(w), 0);
    chk({tag, " done"}, obs_done(w), 0);
    chk({tag, " dz"}, obs_dz(w), 0);
  endtask

  // Issue one operation and check it against integer division; returns at the done cycle.
  task automatic op(input bit w, input int a, input int b, input string tag, input bit tail);
    int nb, lat, eq, er;
    nb = w ? 8 : 4;
    if (b == 0) begin
      eq = (1 << nb) - 1;
      er = a;
    end else begin
      eq = a / b;
      er = a % b;
    end
    if (w) begin st8 = 1'b1; a8 = 8'(a); b8 = 8'(b); end
    else   begin st4 = 1'b1; a4 = 4'(a); b4 = 4'(b); end
    @(posedge clk); #1;
    st4 = 1'b0; st8 = 1'b0;
    lat = 1;
    while (obs_done(w) !== 32'd1 && lat < 40) begin
      chk({tag, " busy"}, obs_busy(w), 32'(b != 0));
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'((b != 0) ? nb + 1 : 1));
    chk({tag, " quotient"}, obs_q(w), 32'(eq));
    chk({tag, " remainder"}, obs_r(w), 32'(er));
    chk({tag, " div_zero"}, obs_dz(w), 32'(b == 0));
    chk({tag, " busy at done"}, obs_busy(w), 0);
    if (b != 0)
      chk({tag, " invariant"},
          32'((int'(obs_q(w)) * b + int'(obs_r(w)) == a) && (int'(obs_r(w)) < b)), 1);
    if (tail) begin
      @(posedge clk); #1;
      chk({tag, " done drop"}, obs_done(w), 0);
    end
  endtask

  initial begin
    int lat, ra, rb;
    rst4 = 1'b1; rst8 = 1'b1; st4 = 1'b0; st8 = 1'b0;
    a4 = '0; b4 = '0; a8 = '0; b8 = '0;
    #12;
    chk_reset(1'b0, "reset4");
    chk_reset(1'b1, "reset8");
    rst4 = 1'b0; rst8 = 1'b0;
    @(posedge clk); #1;

    op(1'b0, 13, 3, "13/3", 1'b1);
    op(1'b0, 7, 0, "7/0", 1'b1);

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        op(1'b0, a, b, $sformatf("sweep %0d/%0d", a, b), 1'b1);

    // Second start held during the first done cycle.
    op(1'b0, 2, 9, "b2b first", 1'b0);
    st4 = 1'b1; a4 = 4'd15; b4 = 4'd1;
    @(posedge clk); #1;
    st4 = 1'b0;
    lat = 1;
    while (done4 !== 1'b1 && lat < 40) begin
      chk("b2b hold q", obs_q(1'b0), 0);
      chk("b2b hold r", obs_r(1'b0), 2);
      @(posedge clk); #1;
      lat++;
    end
    chk("b2b spacing", 32'(lat), 5);
    chk("b2b q", obs_q(1'b0), 15);
    chk("b2b r", obs_r(1'b0), 0);
    @(posedge clk); #1;

    // A start pulse during RUN must be ignored.
    st4 = 1'b1; a4 = 4'd14; b4 = 4'd5;
    @(posedge clk); #1;
    st4 = 1'b0;
    @(posedge clk); #1;
    st4 = 1'b1; a4 = 4'd9; b4 = 4'd3;
    @(posedge clk); #1;
    st4 = 1'b0;
    lat = 3;
    while (done4 !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("ignore latency", 32'(lat), 5);
    chk("ignore q", obs_q(1'b0), 2);
    chk("ignore r", obs_r(1'b0), 4);
    @(posedge clk); #1;
    chk("ignore no restart busy", obs_busy(1'b0), 0);
    chk("ignore done drop", obs_done(1'b0), 0);

    for (int i = 0; i < 40; i++) begin
      ra = int'($urandom_range(255));
      rb = (i % 8 == 0) ? 0 : int'($urandom_range(255));
      op(1'b1, ra, rb, $sformatf("rand8 %0d/%0d", ra, rb), 1'b1);
    end
    op(1'b1, 200, 7, "200/7", 1'b1);

    // Reset mid-RUN aborts with no done pulse.
    st8 = 1'b1; a8 = 8'd255; b8 = 8'd16;
    @(posedge clk); #1;
    st8 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst8 = 1'b1;
    #1;
    chk_reset(1'b1, "abort");
    @(posedge clk); #1;
    rst8 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk("abort no done", obs_done(1'b1), 0);
      @(posedge clk); #1;
    end
    op(1'b1, 255, 16, "fresh 255/16", 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
